// File: rtl/mem_if_stage_pkg.sv
// Shared types for the MAR/MDR memory-interface stage.
// Holds the transaction state encoding and timeout defaults.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE,
        ERR
    } mem_state_t;

    localparam int TIMEOUT_CYC_DEF = 15;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/mem_if_stage_if.sv
// External memory bus between the stage (master) and memory (slave).
interface mem_if_stage_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ce;
    logic              mem_oe;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_ce,
        output mem_oe,
        output mem_we,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_ce,
        input  mem_oe,
        input  mem_we,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_if_stage_regs.sv
// MAR and MDR with load enables; MDR takes bus_in or memory read data.
module mar_mdr_regs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mdr_sel_mem,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q
);

    logic [ADDR_W-1:0] mar_d;
    logic [DATA_W-1:0] mdr_d;

    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (ld_mar) begin
            mar_d = bus_in[ADDR_W-1:0];
        end
        if (ld_mdr) begin
            mdr_d = mdr_sel_mem ? mem_rdata : bus_in;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

endmodule

// File: rtl/mem_if_stage.sv
// Memory-interface stage: MAR/MDR plus a ready-handshaked read/write
// engine with a bounded wait for mem_ready.
module mem_if_stage
    import slc3_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              rd_req,
    input  logic              wr_req,
    mem_if_stage_if.master    mem,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_t       state_q;
    mem_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mdr_from_mem;
    logic             ld_ok;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mdr_from_mem = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = RD;
                    cnt_d   = '0;
                end else if (wr_req) begin
                    state_d = WR;
                    cnt_d   = '0;
                end
            end
            RD, WR: begin
                if (mem.mem_ready) begin
                    state_d      = DONE;
                    mdr_from_mem = (state_q == RD);
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ERR counts as not busy, so the datapath may reload MAR/MDR there.
    assign ld_ok = (state_q == IDLE) || (state_q == ERR);

    mar_mdr_regs #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_regs (
        .Clk        (Clk),
        .Reset      (Reset),
        .bus_in     (bus_in),
        .mem_rdata  (mem.mem_rdata),
        .ld_mar     (LD_MAR && ld_ok),
        .ld_mdr     ((LD_MDR && ld_ok) || mdr_from_mem),
        .mdr_sel_mem(mdr_from_mem),
        .mar_q      (mar_q),
        .mdr_q      (mdr_q)
    );

    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign mem.mem_ce    = (state_q == RD) || (state_q == WR);
    assign mem.mem_oe    = (state_q == RD);
    assign mem.mem_we    = (state_q == WR);

    assign busy = (state_q == RD) || (state_q == WR) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign err  = (state_q == ERR);

endmodule

// File: tb/tb_mem_if_stage.sv
// Self-checking bench for mem_if_stage: directed scenarios plus random
// transactions scored against a cycle-count model of the handshake.
module tb_mem_if_stage;

    localparam int DW     = 16;
    localparam int AW     = 16;
    localparam int T      = 15;
    localparam int BUDGET = 40;

    typedef struct {
        bit          rd;
        bit          wr;
        int          w;
        logic [15:0] rdata;
        bit          sl_mar;
        bit          sl_mdr;
        logic [15:0] sbus;
        bit          bld;
        bit          eld;
        logic [15:0] eval;
    } txn_t;

    typedef struct {
        int          ce;
        int          oe;
        int          we;
        int          busy;
        int          done;
        int          err;
        int          addr_bad;
        int          wdata_bad;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mar;
        logic [15:0] mdr;
    } res_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] bus_in;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_mar;
    logic [15:0] m_mdr;

    mem_if_stage_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

    mem_if_stage #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TIMEOUT_CYC(T)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus_in(bus_in),
        .LD_MAR(LD_MAR),
        .LD_MDR(LD_MDR),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .mem   (mif.master),
        .mar_q (mar_q),
        .mdr_q (mdr_q),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 Clk = ~Clk;

    // Outcome of one request from the handshake rules alone: ready at
    // wait cycle w finishes after w+1 strobe cycles, else T then abort.
    function automatic res_t predict(input txn_t t, input logic [15:0] mar0,
                                     input logic [15:0] mdr0);
        res_t e;
        e = '{default: 0};
        e.mar   = t.sl_mar ? t.sbus : mar0;
        e.mdr   = t.sl_mdr ? t.sbus : mdr0;
        e.addr  = e.mar;
        e.wdata = e.mdr;
        if (t.rd || t.wr) begin
            if (t.w < T) begin
                e.ce   = t.w + 1;
                e.busy = t.w + 2;
                e.done = 1;
                if (t.rd) e.mdr = t.rdata;
            end else begin
                e.ce   = T;
                e.busy = T;
                e.err  = 1;
                if (t.eld) e.mar = t.eval;
            end
            if (t.rd) e.oe = e.ce;
            else      e.we = e.ce;
        end
        return e;
    endfunction

    task automatic drive_txn(input txn_t t, output res_t o);
        bit first;
        first = 1'b1;
        o = '{default: 0};
        rd_req = t.rd;
        wr_req = t.wr;
        LD_MAR = t.sl_mar;
        LD_MDR = t.sl_mdr;
        bus_in = t.sbus;
        mif.mem_ready = 1'($urandom);
        mif.mem_rdata = 16'($urandom);
        @(posedge Clk); #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            LD_MAR = (t.bld && k == 0) || (t.eld && k == T);
            LD_MDR = t.bld && k == 0;
            bus_in = (t.eld && k == T) ? t.eval : 16'hFFFF;
            mif.mem_ready = (k == t.w);
            mif.mem_rdata = (k == t.w) ? t.rdata : 16'($urandom);
            if (mif.mem_ce === 1'b1) begin
                if (first) begin
                    o.addr  = mif.mem_addr;
                    o.wdata = mif.mem_wdata;
                    first   = 1'b0;
                end
                if (mif.mem_addr !== o.addr)   o.addr_bad++;
                if (mif.mem_wdata !== o.wdata) o.wdata_bad++;
                o.ce++;
            end
            o.oe   += int'(mif.mem_oe);
            o.we   += int'(mif.mem_we);
            o.busy += int'(busy);
            o.done += int'(done);
            o.err  += int'(err);
            @(posedge Clk); #1;
        end
        LD_MAR = 1'b0;
        LD_MDR = 1'b0;
        mif.mem_ready = 1'b0;
        o.mar = mar_q;
        o.mdr = mdr_q;
    endtask

    task automatic load_mar(input logic [15:0] v);
        LD_MAR = 1'b1;
        bus_in = v;
        @(posedge Clk); #1;
        LD_MAR = 1'b0;
        m_mar  = v;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({mif.mem_ce, mif.mem_oe, mif.mem_we, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {mif.mem_ce, mif.mem_oe, mif.mem_we, busy, done, err});
        end
        n_checks++;
        if ({mar_q, mdr_q} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: mar=%h mdr=%h want 0 0", mar_q, mdr_q);
        end
        m_mar = 16'h0;
        m_mdr = 16'h0;
    endtask

    task automatic test_read_wait;
        txn_t t;
        res_t e;
        res_t o;
        load_mar(16'h3000);
        n_checks++;
        if (mar_q !== 16'h3000) begin
            n_fail++;
            $display("FAIL rd_mar_load: got %h want 3000", mar_q);
        end
        t = '{default: 0};
        t.rd = 1'b1;
        t.w = 1;
        t.rdata = 16'hBEEF;
        e = predict(t, m_mar, m_mdr);
        drive_txn(t, o);
        n_checks++;
        if (o.addr !== 16'h3000 || o.addr_bad !== 0) begin
            n_fail++;
            $display("FAIL rd_addr: got %h (%0d bad) want 3000", o.addr, o.addr_bad);
        end
        n_checks++;
        if (o.mdr !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rd_mdr: got %h want beef", o.mdr);
        end
        n_checks++;
        if (o.done !== 1 || o.busy !== 3 || o.err !== 0) begin
            n_fail++;
            $display("FAIL rd_timing: done=%0d busy=%0d err=%0d want 1 3 0",
                     o.done, o.busy, o.err);
        end
        m_mar = e.mar;
        m_mdr = e.mdr;
    endtask

    task automatic test_write_zero;
        txn_t t;
        res_t e;
        res_t o;
        load_mar(16'h0042);
        t = '{default: 0};
        t.wr = 1'b1;
        t.w = 0;
        t.sl_mdr = 1'b1;
        t.sbus = 16'h1234;
        e = predict(t, m_mar, m_mdr);
        drive_txn(t, o);
        n_checks++;
        if (o.we !== 1 || o.oe !== 0 || o.done !== 1) begin
            n_fail++;
            $display("FAIL wr_strobes: we=%0d oe=%0d done=%0d want 1 0 1",
                     o.we, o.oe, o.done);
        end
        n_checks++;
        if (o.wdata !== 16'h1234 || o.addr !== 16'h0042) begin
            n_fail++;
            $display("FAIL wr_bus: wdata=%h addr=%h want 1234 0042",
                     o.wdata, o.addr);
        end
        m_mar = e.mar;
        m_mdr = e.mdr;
    endtask

    task automatic test_timeout;
        txn_t t;
        res_t e;
        res_t o;
        t = '{default: 0};
        t.rd = 1'b1;
        t.w = 30;
        t.rdata = 16'hDEAD;
        t.eld = 1'b1;
        t.eval = 16'h5A5A;
        e = predict(t, m_mar, m_mdr);
        drive_txn(t, o);
        n_checks++;
        if (o.ce !== T || o.busy !== T) begin
            n_fail++;
            $display("FAIL to_len: ce=%0d busy=%0d want %0d %0d", o.ce, o.busy, T, T);
        end
        n_checks++;
        if (o.err !== 1 || o.done !== 0) begin
            n_fail++;
            $display("FAIL to_pulse: err=%0d done=%0d want 1 0", o.err, o.done);
        end
        n_checks++;
        if (o.mdr !== e.mdr || o.mar !== e.mar) begin
            n_fail++;
            $display("FAIL to_regs: mar=%h mdr=%h want %h %h",
                     o.mar, o.mdr, e.mar, e.mdr);
        end
        m_mar = e.mar;
        m_mdr = e.mdr;
    endtask

    task automatic test_simultaneous;
        txn_t t;
        res_t e;
        res_t o;
        t = '{default: 0};
        t.rd = 1'b1;
        t.wr = 1'b1;
        t.w = 2;
        t.rdata = 16'($urandom);
        e = predict(t, m_mar, m_mdr);
        drive_txn(t, o);
        n_checks++;
        if (o.oe !== 3 || o.we !== 0 || o.mdr !== e.mdr) begin
            n_fail++;
            $display("FAIL simul: oe=%0d we=%0d mdr=%h want 3 0 %h",
                     o.oe, o.we, o.mdr, e.mdr);
        end
        m_mar = e.mar;
        m_mdr = e.mdr;
    endtask

    task automatic test_load_busy;
        txn_t t;
        res_t e;
        res_t o;
        t = '{default: 0};
        t.rd = 1'b1;
        t.w = 4;
        t.rdata = 16'h0F0F;
        t.bld = 1'b1;
        e = predict(t, m_mar, m_mdr);
        drive_txn(t, o);
        n_checks++;
        if (o.addr_bad !== 0 || o.addr !== m_mar || o.mar !== e.mar) begin
            n_fail++;
            $display("FAIL busy_ld_mar: addr=%h bad=%0d mar=%h want %h",
                     o.addr, o.addr_bad, o.mar, e.mar);
        end
        n_checks++;
        if (o.mdr !== 16'h0F0F) begin
            n_fail++;
            $display("FAIL busy_ld_mdr: got %h want 0f0f", o.mdr);
        end
        m_mar = e.mar;
        m_mdr = e.mdr;
    endtask

    task automatic test_reset_mid;
        load_mar(16'h1357);
        rd_req = 1'b1;
        mif.mem_ready = 1'b0;
        @(posedge Clk); #1;
        rd_req = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        n_checks++;
        if (mif.mem_ce !== 1'b1 || mif.mem_addr !== 16'h1357) begin
            n_fail++;
            $display("FAIL rst_pre: ce=%b addr=%h want 1 1357",
                     mif.mem_ce, mif.mem_addr);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({mif.mem_ce, mif.mem_oe, mif.mem_we, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_strobes: got %b want 000000",
                     {mif.mem_ce, mif.mem_oe, mif.mem_we, busy, done, err});
        end
        n_checks++;
        if (mar_q !== 16'h0 || mdr_q !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid_regs: mar=%h mdr=%h want 0 0", mar_q, mdr_q);
        end
        #2;
        Reset = 1'b0;
        @(posedge Clk); #1;
        n_checks++;
        if (busy !== 1'b0 || mif.mem_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after: busy=%b ce=%b want 0 0", busy, mif.mem_ce);
        end
        m_mar = 16'h0;
        m_mdr = 16'h0;
    endtask

    task automatic test_random;
        txn_t t;
        res_t e;
        res_t o;
        for (int i = 0; i < 24; i++) begin
            t = '{default: 0};
            t.rd     = 1'($urandom);
            t.wr     = 1'($urandom);
            t.w      = int'($urandom_range(0, 20));
            t.rdata  = 16'($urandom);
            t.sl_mar = 1'($urandom);
            t.sl_mdr = 1'($urandom);
            t.sbus   = 16'($urandom);
            t.bld    = (t.rd || t.wr) && 1'($urandom);
            e = predict(t, m_mar, m_mdr);
            drive_txn(t, o);
            n_checks++;
            if ({o.ce, o.oe, o.we, o.busy, o.done, o.err} !==
                {e.ce, e.oe, e.we, e.busy, e.done, e.err}) begin
                n_fail++;
                $display("FAIL rnd%0d_cnt: ce/oe/we/busy/done/err %0d %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d %0d",
                         i, o.ce, o.oe, o.we, o.busy, o.done, o.err,
                         e.ce, e.oe, e.we, e.busy, e.done, e.err);
            end
            n_checks++;
            if (o.mar !== e.mar || o.mdr !== e.mdr) begin
                n_fail++;
                $display("FAIL rnd%0d_regs: mar=%h mdr=%h want %h %h",
                         i, o.mar, o.mdr, e.mar, e.mdr);
            end
            if (e.ce > 0) begin
                n_checks++;
                if (o.addr !== e.addr || o.wdata !== e.wdata ||
                    o.addr_bad !== 0 || o.wdata_bad !== 0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_bus: addr=%h wdata=%h bad=%0d/%0d want %h %h",
                             i, o.addr, o.wdata, o.addr_bad, o.wdata_bad,
                             e.addr, e.wdata);
                end
            end
            m_mar = e.mar;
            m_mdr = e.mdr;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        bus_in = 16'h0;
        LD_MAR = 1'b0;
        LD_MDR = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 16'h0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        test_reset();
        @(posedge Clk); #1;
        test_read_wait();
        test_write_zero();
        test_timeout();
        test_simultaneous();
        test_load_busy();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
